// File: rtl/axis_master.sv
// axis_master: byte-wide AXI4-Stream transmitter with an internal write FIFO.
// User logic pushes {last, data} through din/din_valid/din_ready. The FIFO head
// is presented on m_axis_* and is popped on tvalid && tready.
// Optional feature macro AXIS_MASTER_TLAST_GEN_EN: tlast is generated from a
// PKT_LEN beat counter, and din_last is ignored.
module axis_master #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned PKT_LEN = 16
) (
   input  logic                    m_axis_aclk,
   input  logic                    m_axis_arst,
   input  logic [DATA_W-1:0]       din,
   input  logic                    din_valid,
   input  logic                    din_last,
   output logic                    din_ready,
   output logic [DATA_W-1:0]       m_axis_tdata,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic                    pkt_done,
   output logic [$clog2(DEPTH):0]  fifo_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, STREAM, LAST} tx_state_t;

   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW-1:0]     rd_ptr_nxt;
   logic [AW:0]       count;
   logic [AW:0]       cnt_after_pop;
   logic [AW:0]       count_nxt;
   logic              push;
   logic              pop;
   logic              head_last;
   logic              nxt_head_last;
   tx_state_t         tx_state;
   tx_state_t         tx_state_nxt;

   assign din_ready     = !m_axis_arst && (count < FULL_CNT);
   assign m_axis_tvalid = (count != '0);
   assign push          = din_valid && din_ready;
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign fifo_count    = count;

   assign cnt_after_pop = count - (AW+1)'(pop);
   assign count_nxt     = cnt_after_pop + (AW+1)'(push);
   assign rd_ptr_nxt    = pop ? rd_ptr + 1'b1 : rd_ptr;

   // Empty FIFO forces tdata/tlast to zero so that reset and idle outputs are defined
   assign m_axis_tdata  = m_axis_tvalid ? mem_data[rd_ptr] : '0;
   assign m_axis_tlast  = m_axis_tvalid && head_last;

   // FIFO storage write; push already excludes reset and full
   always_ff @(posedge m_axis_aclk) begin
      if (push) begin
         mem_data[wr_ptr] <= din;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
      if (m_axis_arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
      end
   end

`ifdef AXIS_MASTER_TLAST_GEN_EN
   localparam int unsigned BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
   localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

   logic [BW-1:0] beat_cnt;
   logic [BW-1:0] beat_cnt_nxt;
   logic          unused_din_last;

   assign unused_din_last = din_last;
   assign head_last       = (beat_cnt == LAST_BEAT);
   assign nxt_head_last   = (beat_cnt_nxt == LAST_BEAT);

   // Beat position of the next pop, wrapping after the tlast beat
   always_comb begin
      beat_cnt_nxt = beat_cnt;
      if (pop) begin
         beat_cnt_nxt = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
      end
   end

   // Beat counter register
   always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
      if (m_axis_arst) begin
         beat_cnt <= '0;
      end else begin
         beat_cnt <= beat_cnt_nxt;
      end
   end
`else
   logic mem_last [DEPTH];

   assign head_last = mem_last[rd_ptr];
   // When the FIFO drains to empty this cycle, the new head is the byte being pushed
   assign nxt_head_last = (cnt_after_pop == '0) ? din_last : mem_last[rd_ptr_nxt];

   // Last-flag storage alongside the data
   always_ff @(posedge m_axis_aclk) begin
      if (push) begin
         mem_last[wr_ptr] <= din_last;
      end
   end
`endif

   // Next-state: the state tracks what kind of beat the head presents
   always_comb begin
      tx_state_nxt = tx_state;
      case (tx_state)
         IDLE: begin
            if (push) begin
               tx_state_nxt = nxt_head_last ? LAST : STREAM;
            end
         end
         STREAM, LAST: begin
            if (pop) begin
               if (count_nxt == '0) begin
                  tx_state_nxt = IDLE;
               end else if (nxt_head_last) begin
                  tx_state_nxt = LAST;
               end else begin
                  tx_state_nxt = STREAM;
               end
            end
         end
         default: tx_state_nxt = IDLE;
      endcase
   end

   // State register and the one-cycle frame-complete pulse
   always_ff @(posedge m_axis_aclk or posedge m_axis_arst) begin
      if (m_axis_arst) begin
         tx_state <= IDLE;
         pkt_done <= 1'b0;
      end else begin
         tx_state <= tx_state_nxt;
         pkt_done <= pop && (tx_state == LAST);
      end
   end

endmodule

// File: tb/tb_axis_master.sv
// tb_axis_master: directed self-checking bench for axis_master (DEPTH=4, PKT_LEN=4).
module tb_axis_master;

   logic       clk;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       din_last;
   logic       din_ready;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tlast;
   logic       tready;
   logic       pkt_done;
   logic [2:0] fifo_count;

   int unsigned pass_cnt = 0;
   int unsigned total_cnt = 0;

   axis_master #(
      .DATA_W (8),
      .DEPTH  (4),
      .PKT_LEN(4)
   ) dut (
      .m_axis_aclk  (clk),
      .m_axis_arst  (rst),
      .din          (din),
      .din_valid    (din_valid),
      .din_last     (din_last),
      .din_ready    (din_ready),
      .m_axis_tdata (tdata),
      .m_axis_tvalid(tvalid),
      .m_axis_tlast (tlast),
      .m_axis_tready(tready),
      .pkt_done     (pkt_done),
      .fifo_count   (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      din = 8'h5A; din_last = 1'b1; din_valid = 1'b1; tready = 1'b0;
      step();
      din_valid = 1'b0;
      total_cnt++;
      if (tvalid !== 1'b1 || tdata !== 8'h5A) $display("FAIL rst_pre got v=%b d=%h want v=1 d=5a", tvalid, tdata);
      else pass_cnt++;
      #2 rst = 1'b1;
      #1;
      total_cnt++;
      if (tvalid !== 1'b0) $display("FAIL rst_tvalid got %b want 0", tvalid); else pass_cnt++;
      total_cnt++;
      if (tdata !== 8'h00) $display("FAIL rst_tdata got %h want 00", tdata); else pass_cnt++;
      total_cnt++;
      if (tlast !== 1'b0) $display("FAIL rst_tlast got %b want 0", tlast); else pass_cnt++;
      total_cnt++;
      if (fifo_count !== 3'd0) $display("FAIL rst_count got %0d want 0", fifo_count); else pass_cnt++;
      total_cnt++;
      if (din_ready !== 1'b0) $display("FAIL rst_din_ready got %b want 0", din_ready); else pass_cnt++;
      total_cnt++;
      if (pkt_done !== 1'b0) $display("FAIL rst_pkt_done got %b want 0", pkt_done); else pass_cnt++;
      @(negedge clk);
      rst = 1'b0;
      step();
      total_cnt++;
      if (din_ready !== 1'b1) $display("FAIL rel_din_ready got %b want 1", din_ready); else pass_cnt++;
      total_cnt++;
      if (fifo_count !== 3'd0) $display("FAIL rel_count got %0d want 0", fifo_count); else pass_cnt++;
      total_cnt++;
      if (tvalid !== 1'b0) $display("FAIL rel_tvalid got %b want 0", tvalid); else pass_cnt++;
   endtask

`ifndef AXIS_MASTER_TLAST_GEN_EN
   task automatic test_single_frame();
      logic [7:0] vals [3];
      vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
      tready = 1'b1;
      din_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         din = vals[i];
         din_last = (i == 2);
         step();
         total_cnt++;
         if (tvalid !== 1'b1 || tdata !== vals[i]) $display("FAIL sf_tdata[%0d] got v=%b d=%h want v=1 d=%h", i, tvalid, tdata, vals[i]);
         else pass_cnt++;
         total_cnt++;
         if (tlast !== (i == 2)) $display("FAIL sf_tlast[%0d] got %b want %b", i, tlast, (i == 2));
         else pass_cnt++;
         total_cnt++;
         if (pkt_done !== 1'b0) $display("FAIL sf_pkt_done_early[%0d] got %b want 0", i, pkt_done);
         else pass_cnt++;
      end
      din_valid = 1'b0;
      din_last = 1'b0;
      step();
      total_cnt++;
      if (pkt_done !== 1'b1) $display("FAIL sf_pkt_done got %b want 1", pkt_done); else pass_cnt++;
      total_cnt++;
      if (tvalid !== 1'b0) $display("FAIL sf_drained got %b want 0", tvalid); else pass_cnt++;
      step();
      total_cnt++;
      if (pkt_done !== 1'b0) $display("FAIL sf_pkt_done_width got %b want 0", pkt_done); else pass_cnt++;
   endtask
`endif

   task automatic test_backpressure();
      logic [7:0] exp;
      tready = 1'b0;
      din_last = 1'b0;
      din_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         din = 8'hA0 + 8'(i);
         if (i == 4) begin
            total_cnt++;
            if (din_ready !== 1'b0) $display("FAIL bp_din_ready got %b want 0", din_ready); else pass_cnt++;
         end
         step();
      end
      din_valid = 1'b0;
      total_cnt++;
      if (fifo_count !== 3'd4) $display("FAIL bp_count got %0d want 4", fifo_count); else pass_cnt++;
      total_cnt++;
      if (tvalid !== 1'b1 || tdata !== 8'hA0) $display("FAIL bp_hold got v=%b d=%h want v=1 d=a0", tvalid, tdata);
      else pass_cnt++;
      tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp = 8'hA0 + 8'(i);
         total_cnt++;
         if (tvalid !== 1'b1 || tdata !== exp) $display("FAIL bp_drain[%0d] got v=%b d=%h want v=1 d=%h", i, tvalid, tdata, exp);
         else pass_cnt++;
         step();
      end
      total_cnt++;
      if (fifo_count !== 3'd0 || tvalid !== 1'b0) $display("FAIL bp_empty got cnt=%0d v=%b want cnt=0 v=0", fifo_count, tvalid);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      tready = 1'b0;
      din_last = 1'b0;
      din_valid = 1'b1;
      din = 8'hB0; step();
      din = 8'hB1; step();
      total_cnt++;
      if (fifo_count !== 3'd2) $display("FAIL b2b_prefill got %0d want 2", fifo_count); else pass_cnt++;
      tready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         din = 8'hB2 + 8'(k);
         step();
         exp = 8'hB1 + 8'(k);
         total_cnt++;
         if (fifo_count !== 3'd2) $display("FAIL b2b_count[%0d] got %0d want 2", k, fifo_count); else pass_cnt++;
         total_cnt++;
         if (tdata !== exp) $display("FAIL b2b_order[%0d] got %h want %h", k, tdata, exp); else pass_cnt++;
      end
      din_valid = 1'b0;
      total_cnt++;
      if (tdata !== 8'hBA) $display("FAIL b2b_tail0 got %h want ba", tdata); else pass_cnt++;
      step();
      total_cnt++;
      if (tdata !== 8'hBB) $display("FAIL b2b_tail1 got %h want bb", tdata); else pass_cnt++;
      step();
      total_cnt++;
      if (fifo_count !== 3'd0) $display("FAIL b2b_empty got %0d want 0", fifo_count); else pass_cnt++;
   endtask

`ifndef AXIS_MASTER_TLAST_GEN_EN
   task automatic test_reset_mid_frame();
      tready = 1'b0;
      din_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din = 8'hC0 + 8'(i);
         din_last = (i == 3);
         step();
      end
      din_valid = 1'b0;
      din_last = 1'b0;
      tready = 1'b1;
      total_cnt++;
      if (tdata !== 8'hC0) $display("FAIL mf_beat0 got %h want c0", tdata); else pass_cnt++;
      step();
      total_cnt++;
      if (tdata !== 8'hC1) $display("FAIL mf_beat1 got %h want c1", tdata); else pass_cnt++;
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++;
         if (tlast !== 1'b0 || pkt_done !== 1'b0 || tvalid !== 1'b0)
            $display("FAIL mf_in_reset[%0d] got l=%b p=%b v=%b want 0 0 0", i, tlast, pkt_done, tvalid);
         else pass_cnt++;
         @(negedge clk);
      end
      rst = 1'b0;
      step();
      total_cnt++;
      if (pkt_done !== 1'b0 || fifo_count !== 3'd0) $display("FAIL mf_after got p=%b cnt=%0d want 0 0", pkt_done, fifo_count);
      else pass_cnt++;
      din = 8'h55; din_last = 1'b1; din_valid = 1'b1;
      step();
      din_valid = 1'b0; din_last = 1'b0;
      total_cnt++;
      if (tdata !== 8'h55 || tlast !== 1'b1 || tvalid !== 1'b1)
         $display("FAIL mf_next got d=%h l=%b v=%b want 55 1 1", tdata, tlast, tvalid);
      else pass_cnt++;
      step();
      total_cnt++;
      if (pkt_done !== 1'b1) $display("FAIL mf_next_done got %b want 1", pkt_done); else pass_cnt++;
   endtask
`else
   task automatic test_tlast_gen();
      int unsigned pulses;
      pulses = 0;
      tready = 1'b1;
      din_last = 1'b0;
      din_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         din = 8'hD0 + 8'(i);
         step();
         if (pkt_done === 1'b1) pulses++;
         total_cnt++;
         if (tdata !== 8'hD0 + 8'(i) || tlast !== ((i % 4) == 3))
            $display("FAIL gen_beat[%0d] got d=%h l=%b want d=%h l=%b", i, tdata, tlast, 8'hD0 + 8'(i), ((i % 4) == 3));
         else pass_cnt++;
         total_cnt++;
         if (pkt_done !== (i == 4)) $display("FAIL gen_done[%0d] got %b want %b", i, pkt_done, (i == 4));
         else pass_cnt++;
      end
      din_valid = 1'b0;
      step();
      if (pkt_done === 1'b1) pulses++;
      step();
      if (pkt_done === 1'b1) pulses++;
      total_cnt++;
      if (pulses != 2) $display("FAIL gen_pulses got %0d want 2", pulses); else pass_cnt++;
   endtask
`endif

   initial begin
      rst = 1'b1;
      din = '0;
      din_valid = 1'b0;
      din_last = 1'b0;
      tready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      test_reset();
`ifndef AXIS_MASTER_TLAST_GEN_EN
      test_single_frame();
`endif
      test_backpressure();
      test_back_to_back();
`ifndef AXIS_MASTER_TLAST_GEN_EN
      test_reset_mid_frame();
`else
      test_tlast_gen();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
